trng_uart_word_tx: RTL and testbench

Transmitter end of the random-number path: accepts 32-bit words from the TRNG capture stage (`data_out`/`data_valid` pair), buffers them in a small FIFO, and serializes each word as four UART 8N1 bytes on `tx`. It sits between the capture stage and the board UART pin, so raw entropy streams to a host without the CPU involved.

---
 rtl/trng_uart_pkg.sv | 15 +
 rtl/sync_word_fifo.sv | 69 ++++++
 rtl/trng_uart_word_tx.sv | 159 +++++++++++++++
 tb/tb_trng_uart_word_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_uart_pkg.sv
// Shared types and constants for the TRNG word-to-UART transmitter.
package trng_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BITS_PER_BYTE  = 8;
  localparam int unsigned DROP_MAX       = 255;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO. Pointers wrap modulo DEPTH; a separate level
// register (one bit wider than the pointers) distinguishes full from empty.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // Next pointer and level values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trng_uart_word_tx.sv
// Buffers 32-bit TRNG words and sends each as four UART 8N1 bytes,
// most significant byte first, LSB first within a byte.
module trng_uart_word_tx
  import trng_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   data_in,
  input  logic                          data_valid,
  input  logic                          enable,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_e         state_q;
  logic [CNT_W-1:0]  baud_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       shift_q;
  logic [7:0]        byte_q;
  logic              tx_q;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              push_req;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_rdata;
  logic              baud_end;

  assign push_req = data_valid && enable;
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;
  assign drop     = push_req && fifo_full && !pop;
  assign baud_end = (baud_cnt_q == CNT_W'(DIV - 1));

  sync_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_req),
    .wdata_i (data_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  // Frame sequencer. byte_q holds the byte on the line (shifted right as bits
  // go out); shift_q holds the word's remaining bytes, left-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            byte_idx_q <= '0;
            byte_q     <= fifo_rdata[31:24];
            shift_q    <= {fifo_rdata[23:0], 8'h00};
            tx_q       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state_q    <= ST_DATA;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= byte_q[0];
            byte_q     <= {1'b0, byte_q[7:1]};
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= byte_q[0];
              byte_q    <= {1'b0, byte_q[7:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (byte_idx_q != 2'(BYTES_PER_WORD - 1)) begin
              state_q    <= ST_START;
              byte_idx_q <= byte_idx_q + 1'b1;
              byte_q     <= shift_q[31:24];
              shift_q    <= {shift_q[23:0], 8'h00};
              tx_q       <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'(DROP_MAX)) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_trng_uart_word_tx.sv
// Bench for trng_uart_word_tx at DIV = 10: a line monitor decodes UART
// frames into a queue, expected bytes are queued when words are pushed.
module tb_trng_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        enable = 1'b0;
  logic        tx, busy, overflow;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [9:0]  rx_q[$];
  int          rx_t[$];
  logic [31:0] wq[$];

  logic [9:0]  mon_bits;
  int          mon_cnt = -1;
  int          mon_t = 0;

  trng_uart_word_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .enable     (enable),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples tx at bit centres (bit k at 10k+4 negedges after
  // the first low sample) and records each 10-bit frame with its start cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_cnt = -1;
      end else if (mon_cnt < 0) begin
        if (tx === 1'b0) begin
          mon_cnt = 0;
          mon_t   = cyc;
        end
      end else begin
        if (mon_cnt % 10 == 4) mon_bits[mon_cnt / 10] = tx;
        if (mon_cnt == 94) begin
          rx_q.push_back(mon_bits);
          rx_t.push_back(mon_t);
          mon_cnt = -1;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Push every word in wq on consecutive cycles; the first n_expect go to the
  // scoreboard. Returns at the negedge right after the last push edge.
  task automatic drive_words(input int n_expect);
    logic [31:0] w;
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      w = wq[i];
      data_in    = w;
      data_valid = 1'b1;
      if (i < n_expect)
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_fifo_level: got %0d expected 0", fifo_level); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (rx_q.size() != 0 || tx !== 1'b1) begin n_err++; $display("FAIL rst_idle_line: got %0d frames tx=%b expected 0 frames tx=1", rx_q.size(), tx); end
  endtask

  task automatic test_single();
    int p;
    logic [9:0] f;
    logic [7:0] b;
    int a5_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    apply_reset();
    enable = 1'b1;
    wq = {32'hA5C30F81};
    drive_words(1);
    p = cyc;
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level_after_push: got %0d expected 1", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_after_push: got %b expected 1", busy); end
    while (cyc < p + 400) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_last_stop: got %b expected 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    n_cmp++; if (rx_q.size() != 4) begin n_err++; $display("FAIL single_frame_count: got %0d expected 4", rx_q.size()); end
    if (rx_q.size() == 4) begin
      n_cmp++; if (rx_t[0] - p != 1) begin n_err++; $display("FAIL single_latency: got %0d expected 1", rx_t[0] - p); end
      for (int k = 1; k < 4; k++) begin
        n_cmp++; if (rx_t[k] - rx_t[k-1] != 100) begin n_err++; $display("FAIL single_byte_spacing[%0d]: got %0d expected 100", k, rx_t[k] - rx_t[k-1]); end
      end
      f = rx_q[0];
      for (int k = 0; k < 10; k++) begin
        n_cmp++; if (f[k] !== a5_exp[k][0]) begin n_err++; $display("FAIL single_a5_bit[%0d]: got %b expected %0d", k, f[k], a5_exp[k]); end
      end
      for (int k = 0; k < 4; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL single_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [9:0] f;
    logic [7:0] b;
    apply_reset();
    enable = 1'b1;
    wq = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h5A5AC3C3};
    drive_words(4);
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL b2b_level: got %0d expected 3", fifo_level); end
    wait_frames(16, 4 * 401 + 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d frames expected 16", rx_q.size()); end
    if (ok) begin
      for (int k = 1; k < 16; k++) begin
        n_cmp++;
        if (rx_t[k] - rx_t[k-1] != ((k % 4 == 0) ? 101 : 100)) begin
          n_err++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, rx_t[k] - rx_t[k-1], (k % 4 == 0) ? 101 : 100);
        end
      end
      for (int k = 0; k < 16; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL b2b_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [9:0] f;
    logic [7:0] b;
    apply_reset();
    enable = 1'b1;
    wq = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    drive_words(5);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_count); end
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      data_in    = $urandom;
      data_valid = 1'b1;
    end
    @(negedge clk);
    data_valid = 1'b0;
    n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL ovf_saturate: got %0d expected 255", drop_count); end
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level_still_full: got %0d expected 4", fifo_level); end
    wait_frames(20, 5 * 401 + 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d frames expected 20", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 20; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL ovf_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    bit ok;
    int p0;
    logic [9:0] f;
    logic [7:0] b;
    apply_reset();
    enable = 1'b1;
    wq = {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
    drive_words(5);
    p0 = cyc - 4;
    while (cyc < p0 + 401) @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL fullpop_level_before: got %0d expected 4", fifo_level); end
    data_in    = 32'hF0F1F2F3;
    data_valid = 1'b1;
    for (int k = 3; k >= 0; k--) exp_q.push_back(data_in[8*k +: 8]);
    @(negedge clk);
    data_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL fullpop_level_after: got %0d expected 4", fifo_level); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL fullpop_drop_count: got %0d expected 0", drop_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    wait_frames(24, 5 * 401 + 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL fullpop_timeout: got %0d frames expected 24", rx_q.size()); end
    if (ok) begin
      n_cmp++; if (rx_t[4] - rx_t[3] != 101) begin n_err++; $display("FAIL fullpop_word_gap: got %0d expected 101", rx_t[4] - rx_t[3]); end
      for (int k = 0; k < 24; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL fullpop_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    int p;
    logic [9:0] f;
    logic [7:0] b;
    apply_reset();
    enable = 1'b0;
    wq = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    drive_words(0);
    repeat (50) @(negedge clk);
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL en_no_frames: got %0d frames expected 0", rx_q.size()); end
    n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL en_drop_count: got %0d expected 0", drop_count); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL en_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_busy: got %b expected 0", busy); end
    enable = 1'b1;
    wq = {32'hC35A96E1};
    drive_words(1);
    p = cyc;
    while (cyc < p + 150) @(negedge clk);
    enable = 1'b0;
    wq = {32'h77777777};
    drive_words(0);
    wait_frames(4, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL en_midword_timeout: got %0d frames expected 4", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL en_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
    repeat (500) @(negedge clk);
    n_cmp++; if (rx_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL en_quiet_after: got %0d frames busy=%b expected 0 frames busy=0", rx_q.size(), busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit tx_low_seen;
    int p0;
    logic [9:0] f;
    logic [7:0] b;
    apply_reset();
    enable = 1'b1;
    wq = {32'hA1B2C3D4, 32'hE5F60718};
    drive_words(2);
    p0 = cyc - 1;
    while (cyc < p0 + 1 + 240) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rmid_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL rmid_stats: got ovf=%b drops=%0d expected 0/0", overflow, drop_count); end
    n_cmp++; if (rx_q.size() != 2) begin n_err++; $display("FAIL rmid_frames_before: got %0d expected 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL rmid_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
    rst = 1'b1;
    tx_low_seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low_seen = 1'b1;
    end
    n_cmp++; if (tx_low_seen || rx_q.size() != 0) begin n_err++; $display("FAIL rmid_no_resume: got tx_low=%b frames=%0d expected 0/0", tx_low_seen, rx_q.size()); end
    wq = {32'h3C3CA5A5};
    drive_words(1);
    wait_frames(4, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_new_timeout: got %0d frames expected 4", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        b = exp_q.pop_front();
        f = rx_q.pop_front();
        void'(rx_t.pop_front());
        n_cmp++; if (f !== {1'b1, b, 1'b0}) begin n_err++; $display("FAIL rmid_new_frame[%0d]: got %h expected %h", k, f, {1'b1, b, 1'b0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
